reg_writeback: RTL and testbench

Write-port controller for `reg_file`. It is the single producer of `write_en`, `waddr` and `data_in`. It merges same-cycle ALU results with load data returning from data memory after a delay, and keeps register updates in program order. It also publishes a scoreboard of registers with loads still outstanding, which decode uses for RAW stalls.

---
 rtl/definitions_pkg.sv | 28 ++
 rtl/wb_fifo.sv | 64 ++++++
 rtl/reg_writeback.sv | 173 +++++++++++++++++
 tb/tb_reg_writeback.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/definitions_pkg.sv
// Shared types for the register write-back path: load tags, buffered ALU results and
// write-port source selection.
package definitions;

    localparam int unsigned AddrW   = 4;
    localparam int unsigned DataW   = 8;
    localparam int unsigned NumRegs = 16;

    typedef struct packed {
        logic [3:0] waddr;
        logic       killed;
    } ld_tag_t;

    typedef struct packed {
        logic [3:0] waddr;
        logic [7:0] data;
    } alu_wb_t;

    typedef enum logic [1:0] {WB_NONE, WB_LOAD, WB_ALU_BUF, WB_ALU_DIR} wb_src_t;

    function automatic logic [NumRegs-1:0] reg_onehot(input logic [AddrW-1:0] addr);
        logic [NumRegs-1:0] oh;
        oh       = '0;
        oh[addr] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO with occupancy count; a push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module wb_fifo #(
    parameter int unsigned Width = 12,
    parameter int unsigned Depth = 2,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic [CntW-1:0]  count_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_ok, pop_ok;

    function automatic logic [PtrW-1:0] inc_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(Depth));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        rd_ptr_d = pop_ok ? inc_ptr(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = push_ok ? inc_ptr(wr_ptr_q) : wr_ptr_q;
        count_d  = count_q + CntW'(push_ok) - CntW'(pop_ok);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read while counted as valid.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// Single write-port controller for reg_file: merges returning loads with ALU results in
// program order and tracks registers with live outstanding loads.
module reg_writeback
    import definitions::*;
#(
    parameter int unsigned LD_DEPTH  = 2,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    input  logic [3:0]  alu_waddr,
    input  logic [7:0]  alu_data,
    input  logic        ld_issue,
    input  logic [3:0]  ld_waddr,
    input  logic        mem_rvalid,
    input  logic [7:0]  mem_rdata,
    output logic        write_en,
    output logic [3:0]  waddr,
    output logic [7:0]  data_in,
    output logic        stall,
    output logic [15:0] pending_mask,
    output logic        err
);

    localparam int unsigned LdCntW  = $clog2(LD_DEPTH + 1);
    localparam int unsigned BufCntW = $clog2(BUF_DEPTH + 1);

    ld_tag_t           ld_q [LD_DEPTH];
    ld_tag_t           ld_d [LD_DEPTH];
    logic [LdCntW-1:0] ld_cnt_q, ld_cnt_d;

    logic              we_q, we_d;
    logic [3:0]        waddr_q, waddr_d;
    logic [7:0]        data_q, data_d;
    logic [15:0]       pend_q, pend_d;
    logic              err_q, err_d;

    logic              ld_full, ld_empty, ld_pop, ld_wr, ld_push;
    logic              buf_full, buf_empty, buf_pop, alu_dir, alu_push, alu_acc;
    logic              kill_en;
    logic [3:0]        kill_addr;
    alu_wb_t           buf_head, buf_wdata;
    logic [BufCntW-1:0] buf_cnt;
    wb_src_t           src;

    assign buf_wdata = '{waddr: alu_waddr, data: alu_data};

    wb_fifo #(
        .Width ($bits(alu_wb_t)),
        .Depth (BUF_DEPTH)
    ) u_alu_buf (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (alu_push),
        .wdata_i (buf_wdata),
        .pop_i   (buf_pop),
        .rdata_o (buf_head),
        .count_o (buf_cnt),
        .empty_o (buf_empty),
        .full_o  (buf_full)
    );

    assign ld_full  = (ld_cnt_q == LdCntW'(LD_DEPTH));
    assign ld_empty = (ld_cnt_q == '0);
    assign ld_pop   = mem_rvalid && !ld_empty;
    assign ld_wr    = ld_pop && !ld_q[0].killed;

    // Any non-empty buffer or a winning load diverts the incoming ALU result into the buffer.
    assign buf_pop  = !ld_wr && !buf_empty;
    assign alu_dir  = alu_valid && !ld_wr && buf_empty;
    assign alu_push = alu_valid && !alu_dir && (!buf_full || buf_pop);
    assign alu_acc  = alu_dir || alu_push;
    assign ld_push  = ld_issue && !alu_valid && (!ld_full || ld_pop);

    assign kill_en   = alu_acc || ld_push;
    assign kill_addr = alu_acc ? alu_waddr : ld_waddr;

    // Kill against the current contents first, then pop, then append the new tag.
    always_comb begin
        ld_d     = ld_q;
        ld_cnt_d = ld_cnt_q;
        pend_d   = '0;
        for (int i = 0; i < int'(LD_DEPTH); i++) begin
            if (kill_en && (LdCntW'(i) < ld_cnt_q) && (ld_q[i].waddr == kill_addr)) begin
                ld_d[i].killed = 1'b1;
            end
        end
        if (ld_pop) begin
            for (int i = 0; i < int'(LD_DEPTH) - 1; i++) begin
                ld_d[i] = ld_d[i+1];
            end
            ld_cnt_d = ld_cnt_d - 1'b1;
        end
        if (ld_push) begin
            for (int i = 0; i < int'(LD_DEPTH); i++) begin
                if (LdCntW'(i) == ld_cnt_d) begin
                    ld_d[i] = '{waddr: ld_waddr, killed: 1'b0};
                end
            end
            ld_cnt_d = ld_cnt_d + 1'b1;
        end
        for (int i = 0; i < int'(LD_DEPTH); i++) begin
            if ((LdCntW'(i) < ld_cnt_d) && !ld_d[i].killed) begin
                pend_d = pend_d | reg_onehot(ld_d[i].waddr);
            end
        end
    end

    always_comb begin
        src = WB_NONE;
        if (ld_wr) begin
            src = WB_LOAD;
        end else if (buf_pop) begin
            src = WB_ALU_BUF;
        end else if (alu_dir) begin
            src = WB_ALU_DIR;
        end
        we_d    = (src != WB_NONE);
        waddr_d = waddr_q;
        data_d  = data_q;
        unique case (src)
            WB_LOAD: begin
                waddr_d = ld_q[0].waddr;
                data_d  = mem_rdata;
            end
            WB_ALU_BUF: begin
                waddr_d = buf_head.waddr;
                data_d  = buf_head.data;
            end
            WB_ALU_DIR: begin
                waddr_d = alu_waddr;
                data_d  = alu_data;
            end
            WB_NONE: ;
        endcase
        err_d = err_q
              | (mem_rvalid && ld_empty)
              | (ld_issue && alu_valid)
              | (ld_issue && !alu_valid && ld_full && !ld_pop)
              | (alu_valid && !alu_acc);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(LD_DEPTH); i++) begin
                ld_q[i] <= '0;
            end
            ld_cnt_q <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            data_q   <= '0;
            pend_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            ld_q     <= ld_d;
            ld_cnt_q <= ld_cnt_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            data_q   <= data_d;
            pend_q   <= pend_d;
            err_q    <= err_d;
        end
    end

    assign write_en     = we_q;
    assign waddr        = waddr_q;
    assign data_in      = data_q;
    assign pending_mask = pend_q;
    assign err          = err_q;
    assign stall        = buf_full || ld_full;

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench: expected writes go into a scoreboard queue, a negedge monitor checks every
// write_en against it; status outputs are checked inline at chosen cycles.
module tb_reg_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid;
    logic [3:0]  alu_waddr;
    logic [7:0]  alu_data;
    logic        ld_issue;
    logic [3:0]  ld_waddr;
    logic        mem_rvalid;
    logic [7:0]  mem_rdata;
    logic        write_en;
    logic [3:0]  waddr;
    logic [7:0]  data_in;
    logic        stall;
    logic [15:0] pending_mask;
    logic        err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t exp_q[$];

    always #5 clk = ~clk;

    reg_writeback #(
        .LD_DEPTH  (2),
        .BUF_DEPTH (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alu_valid    (alu_valid),
        .alu_waddr    (alu_waddr),
        .alu_data     (alu_data),
        .ld_issue     (ld_issue),
        .ld_waddr     (ld_waddr),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .write_en     (write_en),
        .waddr        (waddr),
        .data_in      (data_in),
        .stall        (stall),
        .pending_mask (pending_mask),
        .err          (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Inputs are held across one rising edge, then valids drop at the next negedge.
    task automatic drive(input logic av, input logic [3:0] aa, input logic [7:0] ad,
                         input logic li, input logic [3:0] la,
                         input logic mv, input logic [7:0] md);
        alu_valid  = av;
        alu_waddr  = aa;
        alu_data   = ad;
        ld_issue   = li;
        ld_waddr   = la;
        mem_rvalid = mv;
        mem_rdata  = md;
        @(negedge clk);
        alu_valid  = 1'b0;
        ld_issue   = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 1'b0, 8'h00);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_write_en"}, 32'(write_en), 32'd0);
        chk({tag, "_waddr"}, 32'(waddr), 32'd0);
        chk({tag, "_data_in"}, 32'(data_in), 32'd0);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_pending"}, 32'(pending_mask), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && write_en === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got r%0d=0x%0h, expected no write",
                             waddr, data_in);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    if (waddr !== e.a || data_in !== e.d) begin
                        errors++;
                        $display("FAIL wb_order: got r%0d=0x%0h, expected r%0d=0x%0h",
                                 waddr, data_in, e.a, e.d);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        alu_valid  = 1'b0;
        alu_waddr  = '0;
        alu_data   = '0;
        ld_issue   = 1'b0;
        ld_waddr   = '0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        rst_n = 1'b1;

        // Direct ALU write, one-cycle latency.
        exp_q.push_back('{a: 4'd3, d: 8'h5A});
        drive(1'b1, 4'd3, 8'h5A, 1'b0, 4'h0, 1'b0, 8'h00);
        chk("alu_lat_we", 32'(write_en), 32'd1);
        chk("alu_pending", 32'(pending_mask), 32'h0000);

        // Load r7, data returns three cycles after issue.
        drive(1'b0, 4'h0, 8'h00, 1'b1, 4'd7, 1'b0, 8'h00);
        chk("ld7_pending", 32'(pending_mask), 32'h0080);
        idle();
        idle();
        exp_q.push_back('{a: 4'd7, d: 8'h11});
        drive(1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 1'b1, 8'h11);
        chk("ld7_we", 32'(write_en), 32'd1);
        chk("ld7_pending_clr", 32'(pending_mask), 32'h0000);

        // Load return and ALU in the same cycle: load first, ALU next cycle.
        drive(1'b0, 4'h0, 8'h00, 1'b1, 4'd9, 1'b0, 8'h00);
        exp_q.push_back('{a: 4'd9, d: 8'h33});
        exp_q.push_back('{a: 4'd2, d: 8'h22});
        drive(1'b1, 4'd2, 8'h22, 1'b0, 4'h0, 1'b1, 8'h33);
        chk("collide_first_waddr", 32'(waddr), 32'd9);
        idle();
        chk("collide_second_we", 32'(write_en), 32'd1);
        chk("collide_second_waddr", 32'(waddr), 32'd2);

        // Two ALU results behind consecutive load returns fill the skid buffer.
        exp_q.push_back('{a: 4'd10, d: 8'hA0});
        exp_q.push_back('{a: 4'd11, d: 8'hB0});
        exp_q.push_back('{a: 4'd12, d: 8'hC0});
        exp_q.push_back('{a: 4'd1, d: 8'h01});
        exp_q.push_back('{a: 4'd4, d: 8'h04});
        drive(1'b0, 4'h0, 8'h00, 1'b1, 4'd10, 1'b0, 8'h00);
        drive(1'b0, 4'h0, 8'h00, 1'b1, 4'd11, 1'b0, 8'h00);
        chk("ldq_full_stall", 32'(stall), 32'd1);
        chk("ldq_full_pending", 32'(pending_mask), 32'h0C00);
        drive(1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 1'b1, 8'hA0);
        chk("ldq_pop_stall", 32'(stall), 32'd0);
        drive(1'b0, 4'h0, 8'h00, 1'b1, 4'd12, 1'b0, 8'h00);
        drive(1'b1, 4'd1, 8'h01, 1'b0, 4'h0, 1'b1, 8'hB0);
        chk("buf1_stall", 32'(stall), 32'd0);
        drive(1'b1, 4'd4, 8'h04, 1'b0, 4'h0, 1'b1, 8'hC0);
        chk("buf2_stall", 32'(stall), 32'd1);
        idle();
        chk("buf_drain1_stall", 32'(stall), 32'd0);
        idle();
        idle();
        chk("buf_drained_err", 32'(err), 32'd0);

        // Kill: ALU to r5 supersedes the outstanding load to r5.
        drive(1'b0, 4'h0, 8'h00, 1'b1, 4'd5, 1'b0, 8'h00);
        chk("kill_pending_set", 32'(pending_mask), 32'h0020);
        exp_q.push_back('{a: 4'd5, d: 8'h99});
        drive(1'b1, 4'd5, 8'h99, 1'b0, 4'h0, 1'b0, 8'h00);
        chk("kill_pending_clr", 32'(pending_mask), 32'h0000);
        idle();
        drive(1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 1'b1, 8'h44);
        chk("killed_ret_no_we", 32'(write_en), 32'd0);
        chk("killed_ret_err", 32'(err), 32'd0);

        // Return with an empty tag queue.
        drive(1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 1'b1, 8'h55);
        chk("empty_ret_err", 32'(err), 32'd1);
        chk("empty_ret_no_we", 32'(write_en), 32'd0);

        // Reset mid-burst: the buffered r8 result must never appear.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst2_err_clr", 32'(err), 32'd0);
        drive(1'b0, 4'h0, 8'h00, 1'b1, 4'd6, 1'b0, 8'h00);
        exp_q.push_back('{a: 4'd6, d: 8'h66});
        drive(1'b1, 4'd8, 8'h88, 1'b0, 4'h0, 1'b1, 8'h66);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midrst");
        exp_q.delete();
        rst_n = 1'b1;
        repeat (3) idle();
        drive(1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 1'b1, 8'h77);
        chk("post_rst_ret_err", 32'(err), 32'd1);
        chk("post_rst_ret_no_we", 32'(write_en), 32'd0);

        idle();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
